// File: rtl/sweep_pkg.sv
// Shared definitions for the switch/button sweep driver: FSM encoding and
// the bit layout of the status display word.
package sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    // Status display word: {err, state[1:0], done_cnt[7:0], idx[4:0]}
    localparam int unsigned DISP_ERR_BIT = 15;
    localparam int unsigned DISP_ST_LSB  = 13;
    localparam int unsigned DISP_CNT_LSB = 5;
    localparam int unsigned DISP_CNT_W   = 8;
    localparam int unsigned DISP_IDX_W   = 5;
    localparam int unsigned DISP_W       = 16;

endpackage

// File: rtl/swbut_sweep_driver_tick_div.sv
// Free-running tick divider: one tick every 2^DIV_W enabled cycles, with the
// tick on the count==0 cycle. The count is held at zero while disabled.
module tick_div #(
    parameter int unsigned DIV_W = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Next count: advance while enabled, clear otherwise
    always_comb begin
        cnt_d = en ? cnt_q + DIV_W'(1) : '0;
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/swbut_sweep_driver.sv
// Board-level stimulus driver: picks an index from switches, an auto-sweep
// tick or a step button, issues one request at a time, captures the result
// and flags requests whose result never arrives.
module swbut_sweep_driver #(
    parameter int unsigned N       = 16,
    parameter int unsigned IDX_W   = 5,
    parameter int unsigned MAX_IDX = 24,
    parameter int unsigned DIV_W   = 27,
    parameter int unsigned TO_W    = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  in,
    output logic [15:0]  out,
    output logic [N-1:0] req_data,
    output logic         req_valid,
    input  logic         req_ready,
    input  logic [N-1:0] res_data,
    input  logic         res_valid
);
    import sweep_pkg::*;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     result_q, result_d;
    logic             err_q, err_d;
    logic [7:0]       done_cnt_q, done_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             btn_q, btn_d;

    logic             tick;
    logic             auto_mode;
    logic             step_edge;
    logic             manual_trig;
    logic [IDX_W-1:0] sw_idx;
    logic [IDX_W-1:0] next_idx;
    logic             unused_in;

    assign auto_mode = in[15];
    assign sw_idx    = in[IDX_W-1:0];
    assign unused_in = ^in[12:IDX_W];

    tick_div #(
        .DIV_W(DIV_W)
    ) u_tick_div (
        .clk (clk),
        .rst (rst),
        .en  (auto_mode),
        .tick(tick)
    );

    // Trigger qualification and the wrapping sweep increment
    always_comb begin
        step_edge   = !auto_mode && in[14] && !btn_q;
        manual_trig = !auto_mode && !in[14] && (sw_idx != idx_q)
                      && (32'(sw_idx) <= MAX_IDX);
        next_idx    = (idx_q == IDX_W'(MAX_IDX)) ? '0 : idx_q + IDX_W'(1);
    end

    // Request/response FSM next-state, index selection and result capture
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        result_d   = result_q;
        err_d      = err_q;
        done_cnt_d = done_cnt_q;
        to_cnt_d   = to_cnt_q;
        btn_d      = in[14];
        case (state_q)
            S_IDLE: begin
                if (auto_mode) begin
                    if (tick) begin
                        idx_d   = next_idx;
                        state_d = S_ISSUE;
                    end
                end else if (step_edge) begin
                    idx_d   = next_idx;
                    state_d = S_ISSUE;
                end else if (manual_trig) begin
                    idx_d   = sw_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_ready) begin
                    state_d  = S_WAIT;
                    to_cnt_d = '0;
                end
            end
            S_WAIT: begin
                // A result arriving on the terminal-count cycle still wins
                if (res_valid) begin
                    result_d   = res_data;
                    err_d      = 1'b0;
                    done_cnt_d = done_cnt_q + 8'd1;
                    state_d    = S_IDLE;
                end else if (to_cnt_q == '1) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            done_cnt_q <= '0;
            to_cnt_q   <= '0;
            btn_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            err_q      <= err_d;
            done_cnt_q <= done_cnt_d;
            to_cnt_q   <= to_cnt_d;
            btn_q      <= btn_d;
        end
    end

    // Request channel decoded from registered state and index
    always_comb begin
        req_valid               = (state_q == S_ISSUE);
        req_data                = '0;
        req_data[IDX_W-1:0]     = idx_q;
    end

    // Display mux: captured result or packed status word
    always_comb begin
        out = '0;
        if (in[13]) begin
            out[DISP_ERR_BIT]                = err_q;
            out[DISP_ST_LSB +: 2]            = state_q;
            out[DISP_CNT_LSB +: DISP_CNT_W]  = done_cnt_q;
            for (int unsigned i = 0; i < DISP_IDX_W; i++) begin
                if (i < IDX_W) out[i] = idx_q[i];
            end
        end else begin
            for (int unsigned i = 0; i < DISP_W; i++) begin
                if (i < N) out[i] = result_q[i];
            end
        end
    end

endmodule

// File: tb/tb_swbut_sweep_driver.sv
// Randomised bench for swbut_sweep_driver with a transaction-level reference
// model and a simple responder stub returning 2*idx after a random latency.
module tb_swbut_sweep_driver;

    localparam int unsigned N       = 16;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned MAX_IDX = 24;
    localparam int unsigned DIV_W   = 2;
    localparam int unsigned TO_W    = 4;
    localparam int unsigned DIVP    = 1 << DIV_W;
    localparam int unsigned TO_LIM  = (1 << TO_W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  in_sw;
    logic [15:0]  out;
    logic [N-1:0] req_data;
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] res_data;
    logic         res_valid;

    swbut_sweep_driver #(
        .N(N), .IDX_W(IDX_W), .MAX_IDX(MAX_IDX), .DIV_W(DIV_W), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst(rst), .in(in_sw), .out(out),
        .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
        .res_data(res_data), .res_valid(res_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int hs_count = 0;

    // reference model: phase 0 idle, 1 issuing, 2 waiting
    int m_phase, m_idx, m_result, m_err, m_done, m_auto_run, m_age;
    bit m_prev14;

    // responder stub
    bit pend_on = 0;
    int pend_cnt, pend_data;
    bit stub_silent = 0;
    bit spur_en = 0;
    int lat_min = 0, lat_max = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit in15, in14, tick, stp, man, hs;
        int sw, inc;
        hs = !rst && (m_phase == 1) && req_ready;
        if (hs && !stub_silent) begin
            pend_on   = 1;
            pend_cnt  = $urandom_range(lat_max, lat_min);
            pend_data = (2 * m_idx) & 16'hFFFF;
        end
        if (rst) begin
            m_phase = 0; m_idx = 0; m_result = 0; m_err = 0; m_done = 0;
            m_auto_run = 0; m_age = 0; m_prev14 = 0;
            return;
        end
        in15 = in_sw[15];
        in14 = in_sw[14];
        sw   = int'(in_sw[4:0]);
        tick = in15 && (m_auto_run % DIVP == 0);
        stp  = !in15 && in14 && !m_prev14;
        man  = !in15 && !in14 && (sw != m_idx) && (sw <= MAX_IDX);
        inc  = (m_idx == MAX_IDX) ? 0 : m_idx + 1;
        case (m_phase)
            0: begin
                if (tick || stp) begin m_idx = inc; m_phase = 1; end
                else if (man)    begin m_idx = sw;  m_phase = 1; end
            end
            1: if (req_ready) begin m_phase = 2; m_age = 0; end
            default: begin
                if (res_valid) begin
                    m_result = int'(res_data); m_err = 0;
                    m_done = (m_done + 1) % 256; m_phase = 0;
                end else if (m_age == TO_LIM) begin
                    m_err = 1; m_phase = 0;
                end else m_age++;
            end
        endcase
        m_auto_run = in15 ? m_auto_run + 1 : 0;
        m_prev14 = in14;
    endtask

    task automatic stub_drive();
        res_valid = 1'b0;
        res_data  = N'($urandom);
        if (pend_on) begin
            if (pend_cnt == 0) begin
                res_valid = 1'b1;
                res_data  = N'(pend_data);
                pend_on   = 0;
            end else pend_cnt--;
        end else if (spur_en && m_phase != 2 && $urandom_range(7, 0) == 0) begin
            res_valid = 1'b1;
        end
    endtask

    task automatic cycle();
        logic [31:0] exp_out;
        if (req_valid === 1'b1 && req_ready === 1'b1) hs_count++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp_out = in_sw[13] ? ((m_err << 15) | (m_phase << 13) | (m_done << 5) | m_idx)
                            : m_result;
        check("req_valid", {31'd0, req_valid}, (m_phase == 1) ? 32'd1 : 32'd0);
        check("req_data", 32'(req_data), m_idx);
        check("out", 32'(out), exp_out);
        stub_drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int h0, tgt;
    bit reached;

    initial begin
        rst = 1'b1; in_sw = '0; req_ready = 1'b1; res_valid = 1'b0; res_data = '0;
        run(3);
        rst = 1'b0;
        check("rst_out", 32'(out), 0);
        check("rst_req_valid", {31'd0, req_valid}, 0);

        // manual index 5, fixed 3-cycle responder
        lat_min = 3; lat_max = 3;
        h0 = hs_count; in_sw = 16'h0005;
        run(12);
        check("man_reqs", hs_count - h0, 1);
        check("man_out", 32'(out), 10);
        h0 = hs_count; in_sw = 16'h001F;
        run(10);
        check("man_oor_reqs", hs_count - h0, 0);

        // auto sweep with random backpressure and latency
        lat_min = 0; lat_max = 6;
        for (int i = 0; i < 300; i++) begin
            in_sw = 16'h8000 | 16'($urandom_range(31, 0)) | (($urandom_range(1, 0) != 0) ? 16'h2000 : 16'h0);
            req_ready = ($urandom_range(9, 0) < 7);
            cycle();
        end
        req_ready = 1'b1;

        // step button pulses with out-of-range switch index
        lat_min = 0; lat_max = 2;
        in_sw = 16'h001F;
        run(20);
        h0 = hs_count;
        for (int p = 0; p < 3; p++) begin
            in_sw = 16'h401F; cycle();
            in_sw = 16'h001F; run(12);
        end
        check("step3_reqs", hs_count - h0, 3);
        h0 = hs_count;
        in_sw = 16'h401F; run(10);
        in_sw = 16'h001F; run(12);
        check("step_hold_reqs", hs_count - h0, 1);

        // backpressure: ready low for 5 cycles
        tgt = (m_idx + 7) % 25;
        h0 = hs_count; req_ready = 1'b0; in_sw = 16'(tgt);
        run(5);
        check("bp_valid_held", {31'd0, req_valid}, 1);
        req_ready = 1'b1;
        run(10);
        check("bp_reqs", hs_count - h0, 1);

        // timeout then recovery
        stub_silent = 1;
        tgt = (m_idx + 5) % 25;
        in_sw = 16'h2000 | 16'(tgt);
        run(25);
        check("to_err_bit", {31'd0, out[15]}, 1);
        stub_silent = 0;
        tgt = (m_idx + 3) % 25;
        in_sw = 16'h2000 | 16'(tgt);
        run(15);
        check("to_err_clear", {31'd0, out[15]}, 0);

        // reset during WAIT with a late response
        lat_min = 8; lat_max = 8;
        tgt = (m_idx + 9) % 25;
        in_sw = 16'(tgt);
        reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            cycle();
            if (m_phase == 2) reached = 1;
        end
        check("rstw_reached_wait", {31'd0, reached}, 1);
        rst = 1'b1; in_sw = 16'h2000;
        cycle();
        rst = 1'b0;
        run(12);
        check("rstw_out", 32'(out), 0);
        check("rstw_req_valid", {31'd0, req_valid}, 0);

        // random soak
        spur_en = 1; lat_min = 0; lat_max = 5;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(39, 0) == 0) in_sw[15] = ~in_sw[15];
            in_sw[14] = ($urandom_range(3, 0) == 0);
            in_sw[13] = $urandom_range(1, 0);
            if ($urandom_range(9, 0) == 0) in_sw[4:0] = 5'($urandom_range(31, 0));
            req_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(49, 0) == 0) stub_silent = ~stub_silent;
            rst = ($urandom_range(299, 0) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
